nn_scan_loader: RTL and testbench
=================================

Name: nn_scan_loader

Overview:
- Controller that sequences the weight scan chain of the neural-network array: it streams weight words into the chain (LOAD) or rotates the chain for non-destructive readback (READ).
- Sits between the host/config stream and the network's `shift_i` / `weights_i` / `weights_o` scan ports.
- Asserts a hold signal so the inference req/ack fabric is quiesced while the chain is moving.

Parameters:
- DataWidth, 8, width of one weight word and one scan stage.
- ChainWords, 45, number of scan stages in the chain (input + hidden + output neurons).
- CntWidth, $clog2(ChainWords+1), beat counter width (derived; not overridden).

Ports:
- clk_i  in  1  clock; all state on rising edge.
- reset_i  in  1  asynchronous, active-high reset.
- start_i  in  1  start request; sampled only in IDLE.
- mode_i  in  1  0 = LOAD, 1 = READ; sampled with start_i.
- abort_i  in  1  cancels any operation in progress.
- wr_valid_i  in  1  weight-in stream valid.
- wr_data_i  in  DataWidth  weight-in stream data.
- wr_ready_o  out  1  weight-in stream ready.
- rd_valid_o  out  1  readback stream valid.
- rd_data_o  out  DataWidth  readback stream data.
- rd_ready_i  in  1  readback stream ready.
- shift_o  out  1  to network `shift_i`; the chain advances one stage when this is high.
- scan_data_o  out  DataWidth  to network `weights_i`.
- scan_di  in  DataWidth  from network `weights_o` (chain tail).
- busy_o  out  1  high in LOAD or READ.
- net_hold_o  out  1  equals busy_o; gates new inference requests upstream.
- done_o  out  1  one-cycle pulse when all ChainWords beats complete.
- aborted_o  out  1  one-cycle pulse when abort_i ends an active operation.
- beat_cnt_o  out  CntWidth  beats completed in the current operation.

Behaviour:
- Reset (async assert, sync to clk on deassert):
  - State = IDLE, beat counter = 0.
  - All outputs 0; scan_data_o = 0.
- States: IDLE, LOAD, READ.
- IDLE:
  - shift_o = 0, wr_ready_o = 0, rd_valid_o = 0.
  - start_i = 1 → LOAD if mode_i = 0, READ if mode_i = 1. Counter cleared to 0 on the same edge.
- LOAD:
  - wr_ready_o = 1.
  - shift_o = wr_valid_i (combinational, zero latency).
  - scan_data_o = wr_data_i.
  - Each accepted beat (wr_valid_i and wr_ready_o) increments the counter.
  - The beat that brings the counter to ChainWords: counter wraps to 0, done_o pulses next cycle, state → IDLE.
  - wr_valid_i low → no shift; the chain holds.
- READ (rotation; chain contents are restored after ChainWords beats):
  - rd_valid_o = 1, rd_data_o = scan_di.
  - scan_data_o = scan_di (recirculate).
  - shift_o = rd_ready_i.
  - Counting and completion are identical to LOAD, with rd_valid_o and rd_ready_i as the handshake.
  - rd_ready_i low → no shift; rd_data_o stays stable.
- done_o and aborted_o:
  - Registered pulses, high exactly 1 cycle after the completing edge.
  - They are never both high.
- abort_i:
  - In LOAD or READ, wins over a same-cycle final beat: no shift that cycle (shift_o forced 0), state → IDLE, counter → 0, aborted_o pulses. Chain contents are partial/undefined.
  - In IDLE, abort_i is ignored and has priority over start_i (no start that cycle).
- start_i outside IDLE is ignored. start_i held high in IDLE on the cycle done_o pulses begins a new operation.
- ChainWords = 1 is legal: a single beat completes.
- Reset mid-operation: immediate return to IDLE with no done/aborted pulse. The chain holds whatever was shifted.
- busy_o and net_hold_o are high from the cycle after start until the final-beat edge, inclusive of stall cycles.

Test Plan:
- ChainWords = 4, start_i with mode_i = 0, stream 0x11, 0x22, 0x33, 0x44 back-to-back → shift_o high 4 cycles, done_o pulses once 1 cycle after the 4th beat, chain model holds 0x44 at head and 0x11 at tail.
- Same load with wr_valid_i low on alternate cycles → shift_o only on valid cycles, beat_cnt_o goes 1, 2, 3, then 0, done_o after 8 cycles.
- Following load, mode_i = 1, rd_ready_i held 1 → rd_data_o sequence 0x11, 0x22, 0x33, 0x44; chain model unchanged after done_o.
- READ with rd_ready_i = 0 for 3 cycles mid-stream → rd_data_o stable and shift_o = 0 during the stall, full sequence still correct, exactly 4 shifts.
- abort_i asserted together with the 3rd load beat → no shift that cycle, aborted_o pulses, done_o never pulses, busy_o = 0 next cycle.
- reset_i pulsed mid-READ (asynchronously, between edges) → all outputs 0 immediately; a subsequent start_i is accepted normally.

Source files
------------

// File: rtl/nn_scan_loader.sv
// Weight scan-chain sequencer: streams words into the network chain (LOAD) or
// rotates it for non-destructive readback (READ), holding off inference meanwhile.
module nn_scan_loader #(
    parameter  int DataWidth  = 8,
    parameter  int ChainWords = 45,
    localparam int CntWidth   = $clog2(ChainWords + 1)
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    input  logic                 start_i,
    input  logic                 mode_i,
    input  logic                 abort_i,
    input  logic                 wr_valid_i,
    input  logic [DataWidth-1:0] wr_data_i,
    output logic                 wr_ready_o,
    output logic                 rd_valid_o,
    output logic [DataWidth-1:0] rd_data_o,
    input  logic                 rd_ready_i,
    output logic                 shift_o,
    output logic [DataWidth-1:0] scan_data_o,
    input  logic [DataWidth-1:0] scan_di,
    output logic                 busy_o,
    output logic                 net_hold_o,
    output logic                 done_o,
    output logic                 aborted_o,
    output logic [CntWidth-1:0]  beat_cnt_o
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_READ = 2'd2
    } state_t;

    localparam logic [CntWidth-1:0] LastBeat = CntWidth'(ChainWords - 1);

    state_t              state_q, state_d;
    logic [CntWidth-1:0] cnt_q, cnt_d;
    logic                done_q, done_d;
    logic                aborted_q, aborted_d;
    logic                beat_req;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            done_q    <= 1'b0;
            aborted_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            done_q    <= done_d;
            aborted_q <= aborted_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        done_d      = 1'b0;
        aborted_d   = 1'b0;
        beat_req    = 1'b0;
        shift_o     = 1'b0;
        wr_ready_o  = 1'b0;
        rd_valid_o  = 1'b0;
        rd_data_o   = '0;
        scan_data_o = '0;

        case (state_q)
            ST_LOAD: begin
                wr_ready_o  = 1'b1;
                scan_data_o = wr_data_i;
                beat_req    = wr_valid_i;
            end
            ST_READ: begin
                // Tail feeds straight back into the head so the chain rotates.
                rd_valid_o  = 1'b1;
                rd_data_o   = scan_di;
                scan_data_o = scan_di;
                beat_req    = rd_ready_i;
            end
            default: begin
                if (start_i && !abort_i) begin
                    state_d = mode_i ? ST_READ : ST_LOAD;
                    cnt_d   = '0;
                end
            end
        endcase

        if (state_q != ST_IDLE) begin
            // Abort beats a coincident final beat: the chain must not move.
            if (abort_i) begin
                state_d   = ST_IDLE;
                cnt_d     = '0;
                aborted_d = 1'b1;
            end else if (beat_req) begin
                shift_o = 1'b1;
                if (cnt_q == LastBeat) begin
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
        end
    end

    assign busy_o     = (state_q != ST_IDLE);
    assign net_hold_o = busy_o;
    assign done_o     = done_q;
    assign aborted_o  = aborted_q;
    assign beat_cnt_o = cnt_q;

endmodule

// File: tb/tb_nn_scan_loader.sv
// Bench for nn_scan_loader: directed test-plan scenarios plus random traffic,
// checked against an operation-level model and a 4-stage behavioural chain.
module tb_nn_scan_loader;

    localparam int DW = 8;
    localparam int N  = 4;
    localparam int CW = $clog2(N + 1);

    logic          clk_i = 1'b0;
    logic          reset_i;
    logic          start_i, mode_i, abort_i;
    logic          wr_valid_i, rd_ready_i;
    logic [DW-1:0] wr_data_i;
    logic          wr_ready_o, rd_valid_o, shift_o;
    logic [DW-1:0] rd_data_o, scan_data_o, scan_di;
    logic          busy_o, net_hold_o, done_o, aborted_o;
    logic [CW-1:0] beat_cnt_o;

    int n_checks = 0;
    int n_errors = 0;

    // Behavioural network chain: index 0 is the head, N-1 the tail.
    logic [DW-1:0] net [N];
    // Model's expectation of the chain contents.
    logic [DW-1:0] exp_net [N];
    int m_op    = 0;  // 0 idle, 1 load, 2 read
    int m_beats = 0;
    int n_done  = 0;

    always #5 clk_i = ~clk_i;

    always @(posedge clk_i) begin
        if (shift_o) begin
            for (int i = N - 1; i > 0; i--) net[i] <= net[i-1];
            net[0] <= scan_data_o;
        end
    end
    assign scan_di = net[N-1];

    nn_scan_loader #(.DataWidth(DW), .ChainWords(N)) dut (
        .clk_i(clk_i), .reset_i(reset_i), .start_i(start_i), .mode_i(mode_i),
        .abort_i(abort_i), .wr_valid_i(wr_valid_i), .wr_data_i(wr_data_i),
        .wr_ready_o(wr_ready_o), .rd_valid_o(rd_valid_o), .rd_data_o(rd_data_o),
        .rd_ready_i(rd_ready_i), .shift_o(shift_o), .scan_data_o(scan_data_o),
        .scan_di(scan_di), .busy_o(busy_o), .net_hold_o(net_hold_o),
        .done_o(done_o), .aborted_o(aborted_o), .beat_cnt_o(beat_cnt_o)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check_eq({tag, ".shift"}, 32'(shift_o), 0);
        check_eq({tag, ".wr_ready"}, 32'(wr_ready_o), 0);
        check_eq({tag, ".rd_valid"}, 32'(rd_valid_o), 0);
        check_eq({tag, ".rd_data"}, 32'(rd_data_o), 0);
        check_eq({tag, ".scan_data"}, 32'(scan_data_o), 0);
        check_eq({tag, ".busy"}, 32'(busy_o), 0);
        check_eq({tag, ".hold"}, 32'(net_hold_o), 0);
        check_eq({tag, ".done"}, 32'(done_o), 0);
        check_eq({tag, ".aborted"}, 32'(aborted_o), 0);
        check_eq({tag, ".cnt"}, 32'(beat_cnt_o), 0);
    endtask

    // One clock cycle: drive, check combinational outputs, clock, advance model.
    task automatic step(input bit st, input bit md, input bit ab, input bit wv,
                        input logic [DW-1:0] wd, input bit rr);
        bit            e_shift;
        logic [DW-1:0] e_scan, e_rd;
        @(negedge clk_i);
        start_i = st; mode_i = md; abort_i = ab;
        wr_valid_i = wv; wr_data_i = wd; rd_ready_i = rr;
        #1;
        e_shift = 0; e_scan = '0; e_rd = '0;
        if (m_op == 1) begin
            e_shift = wv && !ab;
            e_scan  = wd;
        end else if (m_op == 2) begin
            e_shift = rr && !ab;
            e_scan  = exp_net[N-1];
            e_rd    = exp_net[N-1];
        end
        check_eq("shift", 32'(shift_o), 32'(e_shift));
        check_eq("scan_data", 32'(scan_data_o), 32'(e_scan));
        check_eq("wr_ready", 32'(wr_ready_o), 32'(m_op == 1));
        check_eq("rd_valid", 32'(rd_valid_o), 32'(m_op == 2));
        check_eq("rd_data", 32'(rd_data_o), 32'(e_rd));
        check_eq("hold", 32'(net_hold_o), 32'(m_op != 0));
        @(posedge clk_i);
        #1;
        begin
            bit e_done, e_ab;
            e_done = 0; e_ab = 0;
            if (m_op != 0) begin
                if (ab) begin
                    m_op = 0; m_beats = 0; e_ab = 1;
                end else if (e_shift) begin
                    for (int i = N - 1; i > 0; i--) exp_net[i] = exp_net[i-1];
                    exp_net[0] = e_scan;
                    m_beats++;
                    if (m_beats == N) begin
                        m_beats = 0; m_op = 0; e_done = 1;
                    end
                end
            end else if (st && !ab) begin
                m_op = md ? 2 : 1;
                m_beats = 0;
            end
            if (done_o === 1'b1) n_done++;
            check_eq("done", 32'(done_o), 32'(e_done));
            check_eq("aborted", 32'(aborted_o), 32'(e_ab));
            check_eq("beat_cnt", 32'(beat_cnt_o), 32'(m_beats));
            check_eq("busy", 32'(busy_o), 32'(m_op != 0));
        end
    endtask

    task automatic check_chain(input string tag);
        for (int i = 0; i < N; i++) check_eq(tag, 32'(net[i]), 32'(exp_net[i]));
    endtask

    initial begin
        logic [DW-1:0] words [N];
        int done_before;
        words = '{8'h11, 8'h22, 8'h33, 8'h44};
        reset_i = 1'b1; start_i = 0; mode_i = 0; abort_i = 0;
        wr_valid_i = 0; wr_data_i = '0; rd_ready_i = 0;
        repeat (2) @(posedge clk_i);
        #1 check_idle_outputs("reset");
        @(negedge clk_i) reset_i = 1'b0;

        // Back-to-back load.
        step(1, 0, 0, 0, 8'h00, 0);
        for (int i = 0; i < N; i++) step(0, 0, 0, 1, words[i], 0);
        step(0, 0, 0, 0, 8'h00, 0);
        check_eq("load.head", 32'(net[0]), 32'h44);
        check_eq("load.tail", 32'(net[N-1]), 32'h11);
        check_chain("load.chain");

        // Load with valid on alternate cycles.
        step(1, 0, 0, 0, 8'h00, 0);
        for (int i = 0; i < 2 * N; i++) step(0, 0, 0, (i % 2) == 0, words[i/2], 0);
        check_chain("load2.chain");

        // Readback at full rate; chain must come back unchanged.
        step(1, 1, 0, 0, 8'h00, 0);
        for (int i = 0; i < N; i++) begin
            check_eq("read.seq", 32'(rd_data_o), 32'(words[i]));
            step(0, 0, 0, 0, 8'h00, 1);
        end
        check_chain("read.chain");
        check_eq("read.head", 32'(net[0]), 32'h44);

        // Readback with a 3-cycle stall in the middle.
        step(1, 1, 0, 0, 8'h00, 0);
        for (int i = 0; i < N + 3; i++) step(0, 0, 0, 0, 8'h00, !(i >= 2 && i < 5));
        check_chain("stall.chain");

        // Abort coincident with the 3rd load beat.
        done_before = n_done;
        step(1, 0, 0, 0, 8'h00, 0);
        step(0, 0, 0, 1, 8'hA1, 0);
        step(0, 0, 0, 1, 8'hA2, 0);
        step(0, 0, 1, 1, 8'hA3, 0);
        step(0, 0, 0, 1, 8'hA4, 0);
        step(0, 0, 0, 0, 8'h00, 0);
        check_eq("abort.no_done", 32'(n_done), 32'(done_before));
        check_chain("abort.chain");

        // Restore a known chain, then reset asynchronously mid-read.
        step(1, 0, 0, 0, 8'h00, 0);
        for (int i = 0; i < N; i++) step(0, 0, 0, 1, words[i], 0);
        step(1, 1, 0, 0, 8'h00, 0);
        step(0, 0, 0, 0, 8'h00, 1);
        @(negedge clk_i);
        rd_ready_i = 1'b1;
        #2 reset_i = 1'b1;
        #1 check_idle_outputs("async_rst");
        m_op = 0; m_beats = 0;
        #1 reset_i = 1'b0;
        rd_ready_i = 1'b0;
        check_chain("rst.chain");
        step(1, 1, 0, 0, 8'h00, 0);
        check_eq("rst.restart", 32'(busy_o), 1);
        for (int i = 0; i < N; i++) step(0, 0, 0, 0, 8'h00, 1);
        check_chain("rst.read_chain");

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1,
                 $urandom_range(0, 19) == 0, $urandom_range(0, 2) != 0,
                 DW'($urandom), $urandom_range(0, 2) != 0);
        end
        step(0, 0, 1, 0, 8'h00, 0);
        step(0, 0, 0, 0, 8'h00, 0);
        check_chain("rand.chain");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
